// File: rtl/whac_pkg.sv
// whac_pkg: shared game-state type, hole-count default and popcount helper
// for the whack-a-mole scoring datapath.
package whac_pkg;

  localparam int NUM_HOLES_DEFAULT = 18;
  localparam int POP_MAX_W         = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  // Counts set bits in the low 'width' bits; callers zero-extend to POP_MAX_W.
  function automatic int popcount(input logic [POP_MAX_W-1:0] vec, input int width);
    int count;
    count = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (i < width && vec[i]) count++;
    end
    return count;
  endfunction

endpackage

// File: rtl/edge_detect_bank.sv
// edge_detect_bank: W-wide previous-value register with rise/fall vectors
// formed against the registered copy; clr forces the history to zero.
module edge_detect_bank #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else          q <= d;
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/whack_scorer.sv
// whack_scorer: tracks live moles, scores button hits and escaped moles, and
// ends the game at MISS_LIMIT misses. Optional WHACK_PENALTY_EN docks wrong presses.
module whack_scorer
  import whac_pkg::*;
#(
  parameter int NUM_HOLES  = NUM_HOLES_DEFAULT,
  parameter int SCORE_W    = 10,
  parameter int MISS_W     = 4,
  parameter int MISS_LIMIT = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 game_start,
  input  logic [NUM_HOLES-1:0] mole_positions,
  input  logic [NUM_HOLES-1:0] buttons,
  output logic [NUM_HOLES-1:0] active_moles,
  output logic [SCORE_W-1:0]   score,
  output logic [MISS_W-1:0]    misses,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 game_over
);

  localparam int SCORE_MAX = (1 << SCORE_W) - 1;
  localparam int MISS_MAX  = (1 << MISS_W) - 1;

  game_state_t state;

  logic                 start_ok;
  logic [NUM_HOLES-1:0] btn_q, btn_rise, btn_fall;
  logic [NUM_HOLES-1:0] mole_q, mole_rise, mole_fall;
  logic                 unused_btn;

  logic [NUM_HOLES-1:0] press, hits, leftover, active_next;
  logic                 round_start, round_end;
  int                   hit_cnt, miss_cnt, score_sum, miss_sum;
  logic [SCORE_W-1:0]   score_next;
  logic [MISS_W-1:0]    misses_next;

  assign start_ok   = game_start && (state != PLAY);
  assign unused_btn = ^{btn_q, btn_fall};

  edge_detect_bank #(.W(NUM_HOLES)) u_btn_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .d    (buttons),
    .q    (btn_q),
    .rise (btn_rise),
    .fall (btn_fall)
  );

  // The mole history is wiped on an accepted start so a bitmap already up counts as a fresh round.
  edge_detect_bank #(.W(NUM_HOLES)) u_mole_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_ok),
    .d    (mole_positions),
    .q    (mole_q),
    .rise (mole_rise),
    .fall (mole_fall)
  );

  // Hits are resolved against the current active set before any round turnover.
  always_comb begin
    press       = btn_rise;
    hits        = press & active_moles;
    leftover    = active_moles & ~hits;
    round_start = (|(mole_rise | mole_fall)) && (|mole_positions);
    round_end   = !(|mole_positions) && (|mole_q);
    hit_cnt     = popcount(POP_MAX_W'(hits), NUM_HOLES);
    miss_cnt    = 0;
    active_next = active_moles & ~hits;
    if (round_start) begin
      miss_cnt    = popcount(POP_MAX_W'(leftover), NUM_HOLES);
      active_next = mole_positions;
    end else if (round_end) begin
      miss_cnt    = popcount(POP_MAX_W'(leftover), NUM_HOLES);
      active_next = '0;
    end

    score_sum = int'(score) + hit_cnt;
`ifdef WHACK_PENALTY_EN
    if (|(press & ~active_moles)) score_sum = score_sum - 1;
    if (score_sum < 0) score_sum = 0;
`endif
    if (score_sum > SCORE_MAX) score_sum = SCORE_MAX;
    score_next = SCORE_W'(score_sum);

    miss_sum = int'(misses) + miss_cnt;
    if (miss_sum > MISS_MAX) miss_sum = MISS_MAX;
    misses_next = MISS_W'(miss_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      active_moles <= '0;
      score        <= '0;
      misses       <= '0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (game_start) begin
            state        <= PLAY;
            active_moles <= '0;
            score        <= '0;
            misses       <= '0;
            game_over    <= 1'b0;
          end
        end
        PLAY: begin
          score      <= score_next;
          misses     <= misses_next;
          hit_pulse  <= |hits;
          miss_pulse <= (miss_cnt != 0);
          if (miss_sum >= MISS_LIMIT) begin
            state        <= OVER;
            game_over    <= 1'b1;
            active_moles <= '0;
          end else begin
            active_moles <= active_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_whack_scorer.sv
// tb_whack_scorer: directed vectors for whack_scorer; pulse events are checked
// by a scoreboard monitor, steady state by direct checks.
module tb_whack_scorer;
  import whac_pkg::*;

  localparam int NH = 18;
  localparam int SW = 10;
  localparam int MW = 4;
  localparam int ML = 9;
  localparam logic [NH-1:0] ALL = '1;
`ifdef WHACK_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  typedef struct packed {
    logic          hit;
    logic          miss;
    logic [SW-1:0] score;
    logic [MW-1:0] misses;
    logic [NH-1:0] active;
    logic          over;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          game_start = 1'b0;
  logic [NH-1:0] mole_positions = '0;
  logic [NH-1:0] buttons = '0;
  logic [NH-1:0] active_moles;
  logic [SW-1:0] score;
  logic [MW-1:0] misses;
  logic          hit_pulse, miss_pulse, game_over;

  exp_t exp_q[$];
  exp_t sb_item;
  int   checks = 0;
  int   errors = 0;
  int   exp_score;

  always #5 clk = ~clk;

  whack_scorer #(
    .NUM_HOLES (NH),
    .SCORE_W   (SW),
    .MISS_W    (MW),
    .MISS_LIMIT(ML)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .game_start    (game_start),
    .mole_positions(mole_positions),
    .buttons       (buttons),
    .active_moles  (active_moles),
    .score         (score),
    .misses        (misses),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .game_over     (game_over)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string name, input int s, input int m, input int a, input int o);
    checkOutput({name, "_score"}, int'(score), s);
    checkOutput({name, "_misses"}, int'(misses), m);
    checkOutput({name, "_active"}, int'(active_moles), a);
    checkOutput({name, "_over"}, int'(game_over), o);
  endtask

  task automatic expectEvent(input logic h, input logic m, input int s, input int mi,
                             input int a, input logic o);
    exp_t e;
    e.hit    = h;
    e.miss   = m;
    e.score  = SW'(s);
    e.misses = MW'(mi);
    e.active = NH'(a);
    e.over   = o;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [NH-1:0] mole, input logic [NH-1:0] btn, input logic start);
    mole_positions = mole;
    buttons        = btn;
    game_start     = start;
    @(negedge clk);
    game_start = 1'b0;
  endtask

  // Scoreboard monitor: every pulse cycle must match the next queued event.
  always @(negedge clk) begin
    if (rst_n && (hit_pulse || miss_pulse)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: hit=%0b miss=%0b score=%0d misses=%0d, no event expected",
                 hit_pulse, miss_pulse, score, misses);
      end else begin
        sb_item = exp_q.pop_front();
        checkOutput("sb_hit", int'(hit_pulse), int'(sb_item.hit));
        checkOutput("sb_miss", int'(miss_pulse), int'(sb_item.miss));
        checkOutput("sb_score", int'(score), int'(sb_item.score));
        checkOutput("sb_misses", int'(misses), int'(sb_item.misses));
        checkOutput("sb_active", int'(active_moles), int'(sb_item.active));
        checkOutput("sb_over", int'(game_over), int'(sb_item.over));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    checkState("reset", 0, 0, 0, 0);
    checkOutput("reset_pulses", int'({hit_pulse, miss_pulse}), 0);
    rst_n = 1'b1;

    // IDLE ignores moles and presses
    applyStimulus(NH'(5), NH'(1), 1'b0);
    applyStimulus('0, '0, 1'b0);
    checkState("idle_ignore", 0, 0, 0, 0);

    // Test 1: single scored hit from a held button
    applyStimulus('0, '0, 1'b1);
    checkState("start", 0, 0, 0, 0);
    applyStimulus(NH'(5), '0, 1'b0);
    checkState("round1_up", 0, 0, 5, 0);
    expectEvent(1, 0, 1, 0, 4, 0);
    applyStimulus(NH'(5), NH'(1), 1'b0);
    applyStimulus(NH'(5), NH'(1), 1'b0);
    applyStimulus(NH'(5), NH'(1), 1'b0);
    checkState("held_once", 1, 0, 4, 0);

    // Test 2: escaped moles become misses
    expectEvent(0, 1, 1, 1, 0, 0);
    applyStimulus('0, '0, 1'b0);
    applyStimulus(NH'(5), '0, 1'b0);
    applyStimulus(NH'(5), '0, 1'b0);
    expectEvent(0, 1, 1, 3, 0, 0);
    applyStimulus('0, '0, 1'b0);
    checkState("two_escape", 1, 3, 0, 0);

    // Test 3: presses in the round-end cycle are hits
    applyStimulus(NH'(5), '0, 1'b0);
    applyStimulus(NH'(5), '0, 1'b0);
    expectEvent(1, 0, 3, 3, 0, 0);
    applyStimulus('0, NH'(5), 1'b0);
    applyStimulus('0, '0, 1'b0);
    checkState("last_cycle_hit", 3, 3, 0, 0);
    exp_score = 3;

    // Round changeover with hit against the old set, then a hit on a new mole
    applyStimulus(NH'(5), '0, 1'b0);
    exp_score = 4;
    expectEvent(1, 1, exp_score, 4, 3, 0);
    applyStimulus(NH'(3), NH'(1), 1'b0);
    exp_score = 5;
    expectEvent(1, 0, exp_score, 4, 1, 0);
    applyStimulus(NH'(3), NH'(2), 1'b0);

    // Test 5: wrong-hole press
    applyStimulus(NH'(3), NH'(32), 1'b0);
    if (PEN) exp_score = exp_score - 1;
    checkState("wrong_press", exp_score, 4, 1, 0);
    expectEvent(0, 1, exp_score, 5, 0, 0);
    applyStimulus('0, '0, 1'b0);

    // game_start is ignored while playing
    applyStimulus('0, '0, 1'b1);
    checkState("start_in_play", exp_score, 5, 0, 0);

    // Miss up to the limit; the final cycle also carries a hit
    for (int i = 0; i < 3; i++) begin
      applyStimulus(NH'(1 << i), '0, 1'b0);
      expectEvent(0, 1, exp_score, 6 + i, 0, 0);
      applyStimulus('0, '0, 1'b0);
    end
    applyStimulus(NH'(3), '0, 1'b0);
    exp_score = exp_score + 1;
    expectEvent(1, 1, exp_score, 9, 0, 1);
    applyStimulus('0, NH'(1), 1'b0);
    checkState("over_with_hit", exp_score, 9, 0, 1);
    applyStimulus(NH'(3), NH'(3), 1'b0);
    applyStimulus(NH'(16), '0, 1'b0);
    applyStimulus('0, '0, 1'b0);
    checkState("over_ignore", exp_score, 9, 0, 1);

    // Test 4: nine unhit single-mole rounds from a fresh game
    applyStimulus('0, '0, 1'b1);
    checkState("restart1", 0, 0, 0, 0);
    for (int i = 0; i < ML; i++) begin
      applyStimulus(NH'(1 << i), '0, 1'b0);
      expectEvent(0, 1, 0, i + 1, 0, (i == ML - 1));
      applyStimulus('0, '0, 1'b0);
    end
    checkState("nine_rounds", 0, 9, 0, 1);
    applyStimulus('0, '0, 1'b1);
    checkState("restart2", 0, 0, 0, 0);

    // Wrong press at score 0 never underflows
    applyStimulus('0, NH'(32), 1'b0);
    applyStimulus('0, '0, 1'b0);
    checkState("floor_zero", 0, 0, 0, 0);

    // Test 6: async reset mid-round with score 7
    applyStimulus(NH'(7'h7F), '0, 1'b0);
    expectEvent(1, 0, 7, 0, 0, 0);
    applyStimulus(NH'(7'h7F), NH'(7'h7F), 1'b0);
    applyStimulus(NH'(7'h7F), '0, 1'b0);
    checkState("score7", 7, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkState("async_reset", 0, 0, 0, 0);
    checkOutput("async_reset_pulses", int'({hit_pulse, miss_pulse}), 0);
    mole_positions = '0;
    buttons        = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus('0, '0, 1'b0);
    checkState("post_reset_idle", 0, 0, 0, 0);

    // Score saturation at 2**SW-1
    applyStimulus('0, '0, 1'b1);
    exp_score = 0;
    for (int r = 0; r < 58; r++) begin
      applyStimulus(ALL, '0, 1'b0);
      exp_score = (exp_score + NH > 1023) ? 1023 : exp_score + NH;
      expectEvent(1, 0, exp_score, 0, 0, 0);
      applyStimulus(ALL, ALL, 1'b0);
      applyStimulus('0, '0, 1'b0);
    end
    checkState("saturate", 1023, 0, 0, 0);

    applyStimulus('0, '0, 1'b0);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
